uncrop_pad: RTL and testbench

Restores a cropped pixel stream to full-frame geometry. Each OUT_ROWS x OUT_COLS input frame is re-embedded at (crop_x0, crop_y0) inside an IN_ROWS x IN_COLS output frame, and every position outside the window is filled with a fill pixel. It is the inverse stage of the crop path and sits downstream of it, ahead of any consumer that needs full-size frames. The block generates its own row and column counters and output tuser framing.

---
 rtl/uncrop_pkg.sv | 10 +
 rtl/axis_out_reg.sv | 41 ++++
 rtl/uncrop_pad.sv | 155 +++++++++++++++
 tb/tb_uncrop_pad.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uncrop_pkg.sv
// Shared types for the uncrop/pad stage: FSM states and tuser bit positions.
package uncrop_pkg;
    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam int SOF_BIT = 0;
    localparam int EOL_BIT = 1;
endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register: loads when empty or being drained.
// Latency 1 cycle; holds data/user stable while the sink stalls.
module axis_out_reg #(
    parameter int DATA_W = 10,
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic [USER_W-1:0] usr_i,
    input  logic              rdy_i,
    output logic              load_o,
    output logic              vld_o,
    output logic [DATA_W-1:0] dat_o,
    output logic [USER_W-1:0] usr_o
);
    logic              vld_q;
    logic [DATA_W-1:0] dat_q;
    logic [USER_W-1:0] usr_q;

    assign load_o = !vld_q || rdy_i;

    always_ff @(posedge clk) begin
        if (srst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            usr_q <= '0;
        end else if (push_i) begin
            vld_q <= 1'b1;
            dat_q <= dat_i;
            usr_q <= usr_i;
        end else if (rdy_i) begin
            vld_q <= 1'b0;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
    assign usr_o = usr_q;
endmodule

// File: rtl/uncrop_pad.sv
// Re-embeds a cropped frame at (crop_x0, crop_y0) in a full frame, padding outside the window.
// Optional debug fill pattern enabled by defining UNCROP_PAD_PATTERN_EN.
module uncrop_pad
    import uncrop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int USER_WIDTH      = 2,
    parameter int IN_ROWS         = 20,
    parameter int IN_COLS         = 20,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10,
    parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic [$clog2(IN_COLS)-1:0] crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic                       busy,
    output logic                       err_sync
);
    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam logic [XW:0] X_MAX  = (XW+1)'(IN_COLS - OUT_COLS);
    localparam logic [YW:0] Y_MAX  = (YW+1)'(IN_ROWS - OUT_ROWS);
    localparam logic [XW:0] X_SPAN = (XW+1)'(OUT_COLS);
    localparam logic [YW:0] Y_SPAN = (YW+1)'(OUT_ROWS);

    state_t              state_q, state_d;
    logic [YW-1:0]       row_q, row_d, y0_q, y0_d;
    logic [XW-1:0]       col_q, col_d, x0_q, x0_d;
    logic                err_q, err_d;

    logic                       load, push, in_win, last_col, last_row, at_origin;
    logic [PIXEL_BIT_WIDTH-1:0] fill, pix;
    logic [USER_WIDTH-1:0]      usr;
    logic                       unused_tuser;

    assign unused_tuser = ^s_axis_tuser;

    assign in_win = ({1'b0, row_q} >= {1'b0, y0_q}) && ({1'b0, row_q} < {1'b0, y0_q} + Y_SPAN)
                 && ({1'b0, col_q} >= {1'b0, x0_q}) && ({1'b0, col_q} < {1'b0, x0_q} + X_SPAN);
    assign last_col  = (col_q == XW'(IN_COLS - 1));
    assign last_row  = (row_q == YW'(IN_ROWS - 1));
    assign at_origin = (row_q == y0_q) && (col_q == x0_q);

`ifdef UNCROP_PAD_PATTERN_EN
    assign fill = ({PIXEL_BIT_WIDTH{row_q[0] ^ col_q[0]}} & FILL_VALUE)
                | (PIXEL_BIT_WIDTH'(col_q) ^ PIXEL_BIT_WIDTH'(row_q));
`else
    assign fill = FILL_VALUE;
`endif

    always_comb begin
        usr            = '0;
        usr[SOF_BIT]   = (row_q == '0) && (col_q == '0);
        usr[EOL_BIT]   = last_col;
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        err_d         = 1'b0;
        s_axis_tready = 1'b0;
        push          = 1'b0;
        pix           = fill;
        case (state_q)
            IDLE: begin
                // An SOF beat is only peeked here; holding ready low keeps it on the bus.
                s_axis_tready = !(s_axis_tvalid && s_axis_tuser[SOF_BIT]);
                if (s_axis_tvalid) begin
                    if (s_axis_tuser[SOF_BIT]) begin
                        x0_d    = ({1'b0, crop_x0} > X_MAX) ? X_MAX[XW-1:0] : crop_x0;
                        y0_d    = ({1'b0, crop_y0} > Y_MAX) ? Y_MAX[YW-1:0] : crop_y0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (in_win) begin
                    s_axis_tready = load;
                    push          = s_axis_tvalid && load;
                    pix           = s_axis_tdata;
                    err_d         = push && s_axis_tuser[SOF_BIT] && !at_origin;
                end else begin
                    push = load;
                end
                if (push) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + YW'(1);
                        if (last_row) begin
                            row_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            err_q   <= err_d;
        end
    end

    axis_out_reg #(
        .DATA_W (PIXEL_BIT_WIDTH),
        .USER_W (USER_WIDTH)
    ) u_out (
        .clk    (clk),
        .srst   (srst),
        .push_i (push),
        .dat_i  (pix),
        .usr_i  (usr),
        .rdy_i  (m_axis_tready),
        .load_o (load),
        .vld_o  (m_axis_tvalid),
        .dat_o  (m_axis_tdata),
        .usr_o  (m_axis_tuser)
    );

    assign busy     = (state_q == ACTIVE);
    assign err_sync = err_q;
endmodule

// File: tb/tb_uncrop_pad.sv
// Bench for uncrop_pad: 4x4 full frame, 2x2 crop, scoreboard built from frame geometry.
module tb_uncrop_pad;
    localparam int W = 10, UW = 2, IR = 4, IC = 4, OR = 2, OC = 2, NPIX = OR * OC;
    localparam logic [W-1:0] FILL = '0;

    logic          clk, srst;
    logic          s_vld, s_rdy, m_vld, m_rdy, busy, err;
    logic [W-1:0]  s_dat, m_dat;
    logic [UW-1:0] s_usr, m_usr;
    logic [1:0]    cx, cy;

    typedef struct {
        logic [W-1:0]  d;
        logic [UW-1:0] u;
    } beat_t;

    beat_t         exp_q[$];
    logic [W-1:0]  got_d[$];
    logic [UW-1:0] got_u[$];
    logic [W-1:0]  px_a[NPIX];
    int            n_checks = 0, n_fail = 0, out_cnt = 0, err_cnt = 0, rdy_mode = 0;

    uncrop_pad #(
        .PIXEL_BIT_WIDTH (W), .USER_WIDTH (UW), .IN_ROWS (IR), .IN_COLS (IC),
        .OUT_ROWS (OR), .OUT_COLS (OC), .FILL_VALUE (FILL)
    ) dut (
        .clk (clk), .srst (srst),
        .s_axis_tvalid (s_vld), .s_axis_tready (s_rdy), .s_axis_tdata (s_dat), .s_axis_tuser (s_usr),
        .crop_x0 (cx), .crop_y0 (cy),
        .m_axis_tvalid (m_vld), .m_axis_tready (m_rdy), .m_axis_tdata (m_dat), .m_axis_tuser (m_usr),
        .busy (busy), .err_sync (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] fill_at(input int r, input int c);
`ifdef UNCROP_PAD_PATTERN_EN
        int v;
        v = ((((r + c) % 2) == 1) ? int'(FILL) : 0) | (r ^ c);
        return W'(v);
`else
        return FILL;
`endif
    endfunction

    // Expected full frame: window pixels in raster order, everything else fill.
    task automatic build_exp(input int crx, input int cry);
        int x0, y0;
        beat_t b;
        x0 = (crx > IC - OC) ? IC - OC : crx;
        y0 = (cry > IR - OR) ? IR - OR : cry;
        for (int r = 0; r < IR; r++)
            for (int c = 0; c < IC; c++) begin
                if (r >= y0 && r < y0 + OR && c >= x0 && c < x0 + OC)
                    b.d = px_a[(r - y0) * OC + (c - x0)];
                else
                    b.d = fill_at(r, c);
                b.u    = '0;
                b.u[0] = (r == 0 && c == 0);
                b.u[1] = (c == IC - 1);
                exp_q.push_back(b);
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) px_a[i] = W'($urandom_range(1, (1 << W) - 1));
    endtask

    task automatic fill_seq();
        for (int i = 0; i < NPIX; i++) px_a[i] = W'(i + 1);
    endtask

    task automatic send_frame(input int crx, input int cry, input int sof2, input int abort_at,
                              input bit gaps, output bit aborted);
        aborted = 1'b0;
        build_exp(crx, cry);
        cx = 2'(crx);
        cy = 2'(cry);
        for (int i = 0; i < NPIX; i++) begin
            int budget = 0;
            bit done = 1'b0;
            while (!done) begin
                @(negedge clk); #1;
                if (abort_at >= 0 && out_cnt >= abort_at) begin
                    s_vld   = 1'b0;
                    aborted = 1'b1;
                    return;
                end
                if (gaps && $urandom_range(0, 3) == 0) begin
                    s_vld = 1'b0;
                end else begin
                    s_vld    = 1'b1;
                    s_dat    = px_a[i];
                    s_usr    = '0;
                    s_usr[0] = (i == 0) || (i == sof2);
                end
                #1;
                done = s_vld && s_rdy;
                budget++;
                if (budget > 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL input_timeout: beat %0d not accepted, expected acceptance within 200 cycles", i);
                    s_vld = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk); #1;
        s_vld = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check("drain_left", exp_q.size(), 0);
        @(negedge clk); #3;
        check("busy_after_frame", busy, 1'b0);
    endtask

    initial begin
        m_rdy = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       m_rdy = 1'b1;
                1:       m_rdy = ~m_rdy;
                default: m_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: scoreboard on each output handshake plus stall-hold check.
    initial begin
        bit            stall_prev = 1'b0;
        logic [W-1:0]  prev_d;
        logic [UW-1:0] prev_u;
        beat_t         e;
        forever begin
            @(negedge clk); #3;
            if (srst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) check("hold_stable", {m_vld, m_dat, m_usr}, {1'b1, prev_d, prev_u});
                if (m_vld && m_rdy) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL stray_output: got data %0h user %0h, expected no output", m_dat, m_usr);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {m_dat, m_usr}, {e.d, e.u});
                    end
                    got_d.push_back(m_dat);
                    got_u.push_back(m_usr);
                    out_cnt++;
                end
                stall_prev = m_vld && !m_rdy;
                prev_d     = m_dat;
                prev_u     = m_usr;
                if (err) err_cnt++;
            end
        end
    end

    initial begin
        int base, e0, oc0;
        bit ab;
        srst = 1'b1; s_vld = 1'b0; s_dat = '0; s_usr = '0; cx = '0; cy = '0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_m_vld", m_vld, 1'b0);
        check("rst_m_dat", m_dat, '0);
        check("rst_m_usr", m_usr, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_s_rdy_idle", s_rdy, 1'b1);
        @(negedge clk); #1;
        srst = 1'b0;

        // Basic placement, always-ready sink.
        rdy_mode = 0; fill_seq(); base = got_d.size(); e0 = err_cnt;
        send_frame(1, 1, -1, -1, 1'b0, ab);
        drain();
        check("basic_p1", got_d[base + 5], 10'd1);
        check("basic_p2", got_d[base + 6], 10'd2);
        check("basic_p3", got_d[base + 9], 10'd3);
        check("basic_p4", got_d[base + 10], 10'd4);
`ifdef UNCROP_PAD_PATTERN_EN
        check("pattern_0_3", got_d[base + 3], 10'd3);
        check("pattern_3_3", got_d[base + 15], 10'd0);
`else
        check("basic_fill_0", got_d[base + 0], 10'd0);
        check("basic_fill_7", got_d[base + 7], 10'd0);
`endif
        check("basic_sof_user", got_u[base + 0], 2'b01);
        check("basic_eol_user", got_u[base + 3], 2'b10);
        check("basic_no_err", err_cnt - e0, 0);

        // Same frame with alternating sink ready.
        rdy_mode = 1; fill_seq(); base = got_d.size();
        send_frame(1, 1, -1, -1, 1'b0, ab);
        drain();
        check("bp_p1", got_d[base + 5], 10'd1);
        check("bp_p4", got_d[base + 10], 10'd4);
        check("bp_count", got_d.size() - base, 16);

        // Clamp: origin (3,3) lands at (2,2).
        rdy_mode = 0; fill_seq(); base = got_d.size();
        send_frame(3, 3, -1, -1, 1'b0, ab);
        drain();
        check("clamp_p1", got_d[base + 10], 10'd1);
        check("clamp_p2", got_d[base + 11], 10'd2);
        check("clamp_p4", got_d[base + 15], 10'd4);

        // Non-SOF beat in IDLE is dropped with a single-cycle error.
        e0 = err_cnt; oc0 = out_cnt;
        @(negedge clk); #1;
        s_vld = 1'b1; s_dat = 10'h3AA; s_usr = 2'b00;
        #1;
        check("idle_drop_rdy", s_rdy, 1'b1);
        @(negedge clk); #1;
        s_vld = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("idle_drop_err", err_cnt - e0, 1);
        check("idle_drop_no_out", out_cnt - oc0, 0);
        check("idle_drop_busy", busy, 1'b0);

        // Extra SOF on the third cropped pixel.
        e0 = err_cnt; fill_rand();
        send_frame(0, 1, 2, -1, 1'b0, ab);
        drain();
        check("midsof_err", err_cnt - e0, 1);

        // Reset after six outputs, then restart.
        fill_rand();
        send_frame(1, 1, -1, out_cnt + 6, 1'b0, ab);
        check("rst_aborted", ab, 1'b1);
        srst = 1'b1;
        exp_q.delete();
        @(negedge clk); #1;
        srst = 1'b0;
        #2;
        check("mid_rst_vld", m_vld, 1'b0);
        check("mid_rst_dat", m_dat, '0);
        check("mid_rst_busy", busy, 1'b0);
        fill_seq(); base = got_d.size();
        send_frame(1, 1, -1, -1, 1'b0, ab);
        drain();
        check("restart_sof", got_u[base + 0], 2'b01);
        check("restart_p1", got_d[base + 5], 10'd1);

        // Randomized frames: crop, sink pattern, source gaps, optional misplaced SOF.
        for (int f = 0; f < 16; f++) begin
            int s2;
            rdy_mode = $urandom_range(0, 2);
            s2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NPIX - 1)) : -1;
            e0 = err_cnt;
            fill_rand();
            send_frame($urandom_range(0, 3), $urandom_range(0, 3), s2, -1, 1'b1, ab);
            drain();
            check("rand_err", err_cnt - e0, (s2 >= 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
